// File: rtl/j68_pkg.sv
// ----------------------------------------------------------------------------
// j68_pkg
// Shared definitions for the J68 microcode sequencer: microcode address
// width, the address type, the opcode field encodings and a wrapping
// increment helper.
// No ports (package).
// ----------------------------------------------------------------------------
package j68_pkg;

    localparam int UPC_W = 11;

    typedef logic [UPC_W-1:0] upc_t;

    // Opcode field inst[19:17]; any encoding not listed falls through
    // to sequential execution.
    localparam logic [2:0] OP_LOOP = 3'd0;
    localparam logic [2:0] OP_CALL = 3'd1;
    localparam logic [2:0] OP_JMPC = 3'd2;
    localparam logic [2:0] OP_JMP  = 3'd3;
    localparam logic [2:0] OP_DISP = 3'd4;

    // Microcode addresses wrap at the top of the 2K space.
    function automatic upc_t upc_inc(input upc_t a);
        return a + upc_t'(1);
    endfunction

endpackage

// File: rtl/j68_useq_if.sv
// ----------------------------------------------------------------------------
// j68_useq_if
// Bundles the sequencer's core-side signals: enables, ROM data, condition,
// decode address, loop-unit handshake and the sequencer outputs.
// Modports:
//   slave  - the sequencer (consumes ROM/loop inputs, drives rom_addr etc.)
//   master - the surrounding core / ROM / loop unit
// Signals:
//   clk_ena, stall       clock enable and bus wait
//   inst_in[19:0]        ROM data for the current upc
//   cond                 selected condition flag for JMPC
//   dec_addr[10:0]       decode-ROM entry address for DISPATCH
//   loop_branch/skip/pc  loop-unit redirect, zero-count skip, loop start
//   rom_addr[10:0]       ROM read address (next PC when advancing)
//   pc_out[10:0]         upc+1 of the current instruction
//   i_fetch              current word consumed this cycle
//   stk_err              sticky return-stack error
// ----------------------------------------------------------------------------
interface j68_useq_if;
    import j68_pkg::*;

    logic        clk_ena;
    logic        stall;
    logic [19:0] inst_in;
    logic        cond;
    upc_t        dec_addr;
    logic        loop_branch;
    logic        loop_skip;
    upc_t        loop_pc;
    upc_t        rom_addr;
    upc_t        pc_out;
    logic        i_fetch;
    logic        stk_err;

    modport slave (
        input  clk_ena, stall, inst_in, cond, dec_addr,
               loop_branch, loop_skip, loop_pc,
        output rom_addr, pc_out, i_fetch, stk_err
    );

    modport master (
        output clk_ena, stall, inst_in, cond, dec_addr,
               loop_branch, loop_skip, loop_pc,
        input  rom_addr, pc_out, i_fetch, stk_err
    );

endinterface

// File: rtl/j68_useq_stack.sv
// ----------------------------------------------------------------------------
// j68_useq_stack
// Return-address LIFO, DEPTH entries of UPC_W bits. Implemented as a circular
// buffer so a push while full simply overwrites the oldest entry.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write push_data on top (wraps over oldest when full)
//   pop          remove top entry (ignored when empty)
//   push_data    return address to store
//   top_data     current top entry
//   empty, full  occupancy flags
// ----------------------------------------------------------------------------
module j68_useq_stack
    import j68_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  upc_t push_data,
    output upc_t top_data,
    output logic empty,
    output logic full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] sp_q, sp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    upc_t          mem_q [DEPTH];

    // sp points at the next free slot; with DEPTH a power of two the
    // pointer wraps naturally, and when full it lands on the oldest entry.
    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CW'(DEPTH));
    assign top_data = mem_q[sp_q - PW'(1)];

    always_comb begin
        sp_d  = sp_q;
        cnt_d = cnt_q;
        if (push) begin
            sp_d = sp_q + PW'(1);
            if (!full) begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (pop && !empty) begin
            sp_d  = sp_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q  <= '0;
            cnt_q <= '0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by cnt_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[sp_q] <= push_data;
        end
    end

endmodule

// File: rtl/j68_useq.sv
// ----------------------------------------------------------------------------
// j68_useq
// Microcode sequencer for the J68 core. Drives the synchronous microcode ROM
// address and resolves sequential flow, jumps, conditional jumps, call/return
// through a small return stack, decode dispatch and loop-unit redirects.
// Ports:
//   clk     CPU clock
//   rst_n   asynchronous active-low reset
//   bus     j68_useq_if.slave: enables, ROM data, cond, dec_addr, loop unit
//           inputs; rom_addr, pc_out, i_fetch, stk_err outputs
// ----------------------------------------------------------------------------
module j68_useq
    import j68_pkg::*;
#(
    parameter upc_t RST_ADDR  = 11'd0,
    parameter int   STK_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    j68_useq_if.slave    bus
);

    upc_t upc_q, upc_d;
    logic v_q, v_d;
    logic stk_err_q, stk_err_d;

    logic       adv;
    upc_t       pc_nxt;
    upc_t       upc_plus1;
    logic [2:0] opcode;
    upc_t       target;
    logic       push_req;
    logic       pop_req;
    logic       err_set;
    upc_t       stk_top;
    logic       stk_empty;
    logic       stk_full;
    logic       unused_inst_bits;

    assign unused_inst_bits = ^bus.inst_in[16:12];

    // v marks that inst_in holds the word for upc; it stays low for the first
    // enabled cycle after reset while the ROM produces its first word.
    assign adv       = bus.clk_ena & ~bus.stall & v_q;
    assign upc_plus1 = upc_inc(upc_q);
    assign opcode    = bus.inst_in[19:17];
    assign target    = bus.inst_in[10:0];

    // Next-PC selection. A loop-unit branch overrides the opcode entirely,
    // including any stack side effect of CALL/RET.
    always_comb begin
        pc_nxt   = upc_plus1;
        push_req = 1'b0;
        pop_req  = 1'b0;
        err_set  = 1'b0;
        if (bus.loop_branch) begin
            pc_nxt = bus.loop_pc;
        end else begin
            case (opcode)
                OP_LOOP: pc_nxt = bus.loop_skip ? upc_inc(target) : upc_plus1;
                OP_CALL: begin
                    push_req = 1'b1;
                    err_set  = stk_full;
                    pc_nxt   = target;
                end
                OP_JMPC: pc_nxt = bus.cond ? target : upc_plus1;
                OP_JMP: begin
                    if (bus.inst_in[11]) begin
                        if (stk_empty) begin
                            pc_nxt  = RST_ADDR;
                            err_set = 1'b1;
                        end else begin
                            pop_req = 1'b1;
                            pc_nxt  = stk_top;
                        end
                    end else begin
                        pc_nxt = target;
                    end
                end
                OP_DISP: pc_nxt = bus.dec_addr;
                default: pc_nxt = upc_plus1;
            endcase
        end
    end

    // ROM has one cycle of latency, so presenting pc_nxt now makes any
    // redirect bubble-free; when not advancing the ROM re-reads upc.
    assign bus.rom_addr = adv ? pc_nxt : upc_q;
    assign bus.pc_out   = upc_plus1;
    assign bus.i_fetch  = adv;
    assign bus.stk_err  = stk_err_q;

    always_comb begin
        upc_d     = adv ? pc_nxt : upc_q;
        v_d       = v_q | (bus.clk_ena & ~bus.stall);
        stk_err_d = stk_err_q | (adv & err_set);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upc_q     <= RST_ADDR;
            v_q       <= 1'b0;
            stk_err_q <= 1'b0;
        end else begin
            upc_q     <= upc_d;
            v_q       <= v_d;
            stk_err_q <= stk_err_d;
        end
    end

    j68_useq_stack #(
        .DEPTH (STK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (adv & push_req),
        .pop       (adv & pop_req),
        .push_data (upc_plus1),
        .top_data  (stk_top),
        .empty     (stk_empty),
        .full      (stk_full)
    );

endmodule

// File: tb/tb_j68_useq.sv
// ----------------------------------------------------------------------------
// tb_j68_useq
// Directed, table-driven bench for the J68 microcode sequencer. The bench
// plays the part of the microcode ROM by presenting, each cycle, the word
// that belongs at the sequencer's current upc, and checks the combinational
// outputs half a cycle before the next rising edge.
// ----------------------------------------------------------------------------
module tb_j68_useq;
    import j68_pkg::*;

    typedef struct {
        logic        clk_ena;
        logic        stall;
        logic [19:0] inst;
        logic        cond;
        upc_t        dec_addr;
        logic        lb;
        logic        ls;
        upc_t        lpc;
        upc_t        exp_rom;
        upc_t        exp_pc;
        logic        exp_fetch;
        logic        exp_err;
    } vec_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    j68_useq_if bus ();

    j68_useq #(
        .RST_ADDR  (11'd0),
        .STK_DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [19:0] enc(input logic [2:0] op, input logic b11, input upc_t t);
        return {op, 5'b00000, b11, t};
    endfunction

    function automatic vec_t mkv(input logic ce, input logic st, input logic [19:0] inst,
                                 input logic cnd, input upc_t dec, input logic lb,
                                 input logic ls, input upc_t lpc, input upc_t erom,
                                 input upc_t epc, input logic efetch, input logic eerr);
        vec_t v;
        v.clk_ena   = ce;
        v.stall     = st;
        v.inst      = inst;
        v.cond      = cnd;
        v.dec_addr  = dec;
        v.lb        = lb;
        v.ls        = ls;
        v.lpc       = lpc;
        v.exp_rom   = erom;
        v.exp_pc    = epc;
        v.exp_fetch = efetch;
        v.exp_err   = eerr;
        return v;
    endfunction

    // One comparison: counts it, and reports a FAIL line on mismatch.
    task automatic compare(input string tag, input string what, input logic [10:0] act,
                           input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s %s: got %h expected %h", tag, what, act, exp);
        end
    endtask

    // Drive all sequencer inputs from a vector record.
    task automatic applyStimulus(input vec_t v);
        bus.clk_ena     = v.clk_ena;
        bus.stall       = v.stall;
        bus.inst_in     = v.inst;
        bus.cond        = v.cond;
        bus.dec_addr    = v.dec_addr;
        bus.loop_branch = v.lb;
        bus.loop_skip   = v.ls;
        bus.loop_pc     = v.lpc;
    endtask

    // Compare all four outputs against the record's expectations.
    task automatic checkOutput(input string tag, input vec_t v);
        compare(tag, "rom_addr", bus.rom_addr, v.exp_rom);
        compare(tag, "pc_out", bus.pc_out, v.exp_pc);
        compare(tag, "i_fetch", {10'd0, bus.i_fetch}, {10'd0, v.exp_fetch});
        compare(tag, "stk_err", {10'd0, bus.stk_err}, {10'd0, v.exp_err});
    endtask

    // Apply at the falling edge, check 1 time unit later.
    task automatic stepCheck(input string tag, input vec_t v);
        @(negedge clk);
        applyStimulus(v);
        #1;
        checkOutput(tag, v);
    endtask

    vec_t vecs [21];
    vec_t cv;
    upc_t callUpc;
    upc_t retUpc [5];
    upc_t retExp [5];
    localparam logic [19:0] NOP = {3'd7, 17'd0};
    localparam logic [19:0] RET = {3'd3, 5'd0, 1'b1, 11'd0};

    initial begin
        errors = 0;
        checks = 0;

        // Straight-line program: reset exit, sequential, call/return, loop
        // skip and loop-branch priority, dispatch, stall/enable hold, wrap
        // of upc+1 at 0x7FF, JMPC both ways, RET suppressed by loop_branch.
        vecs[0]  = mkv(1,0,NOP,                   0,0,0,0,0,       11'h000,11'h001,0,0);
        vecs[1]  = mkv(1,0,NOP,                   0,0,0,0,0,       11'h001,11'h001,1,0);
        vecs[2]  = mkv(1,0,NOP,                   0,0,0,0,0,       11'h002,11'h002,1,0);
        vecs[3]  = mkv(1,0,enc(3,0,11'h005),      0,0,0,0,0,       11'h005,11'h003,1,0);
        vecs[4]  = mkv(1,0,enc(1,0,11'h100),      0,0,0,0,0,       11'h100,11'h006,1,0);
        vecs[5]  = mkv(1,0,RET,                   0,0,0,0,0,       11'h006,11'h101,1,0);
        vecs[6]  = mkv(1,0,enc(3,0,11'h020),      0,0,0,0,0,       11'h020,11'h007,1,0);
        vecs[7]  = mkv(1,0,enc(0,0,11'h028),      0,0,0,1,0,       11'h029,11'h021,1,0);
        vecs[8]  = mkv(1,0,enc(3,0,11'h300),      0,0,1,0,11'h021, 11'h021,11'h02A,1,0);
        vecs[9]  = mkv(1,0,enc(0,0,11'h028),      0,0,0,0,0,       11'h022,11'h022,1,0);
        vecs[10] = mkv(1,0,enc(1,0,11'h040),      0,0,1,0,11'h021, 11'h021,11'h023,1,0);
        vecs[11] = mkv(1,0,enc(4,0,11'h000),      0,11'h155,0,0,0, 11'h155,11'h022,1,0);
        vecs[12] = mkv(1,1,enc(3,0,11'h7FF),      0,0,0,0,0,       11'h155,11'h156,0,0);
        vecs[13] = mkv(0,0,enc(3,0,11'h7FF),      0,0,0,0,0,       11'h155,11'h156,0,0);
        vecs[14] = mkv(1,0,enc(3,0,11'h7FF),      0,0,0,0,0,       11'h7FF,11'h156,1,0);
        vecs[15] = mkv(1,1,enc(2,0,11'h010),      0,0,0,0,0,       11'h7FF,11'h000,0,0);
        vecs[16] = mkv(1,0,enc(2,0,11'h010),      0,0,0,0,0,       11'h000,11'h000,1,0);
        vecs[17] = mkv(1,0,enc(3,0,11'h7FF),      0,0,0,0,0,       11'h7FF,11'h001,1,0);
        vecs[18] = mkv(1,0,enc(2,0,11'h010),      1,0,0,0,0,       11'h010,11'h000,1,0);
        vecs[19] = mkv(1,0,RET,                   0,0,1,0,11'h030, 11'h030,11'h011,1,0);
        vecs[20] = mkv(1,0,enc(3,0,11'h040),      0,0,0,0,0,       11'h040,11'h031,1,0);

        // Hold reset with the enable low, check reset-state outputs.
        rst_n = 1'b0;
        applyStimulus(mkv(0,0,NOP,0,0,0,0,0,0,0,0,0));
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset", mkv(0,0,NOP,0,0,0,0,0,11'h000,11'h001,0,0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            stepCheck($sformatf("vec%0d", i), vecs[i]);
        end

        // Five nested calls into a 4-deep stack: the fifth overwrites the
        // oldest return address and raises the sticky error.
        for (int i = 0; i < 5; i++) begin
            callUpc = 11'h040 + upc_t'(16 * i);
            cv = mkv(1,0,enc(1,0,callUpc + 11'h010),0,0,0,0,0,
                     callUpc + 11'h010, callUpc + 11'h001, 1, 0);
            stepCheck($sformatf("call%0d", i), cv);
        end

        // Four returns in LIFO order, then an underflow to RST_ADDR.
        retUpc = '{11'h090, 11'h081, 11'h071, 11'h061, 11'h051};
        retExp = '{11'h081, 11'h071, 11'h061, 11'h051, 11'h000};
        for (int i = 0; i < 5; i++) begin
            cv = mkv(1,0,RET,0,0,0,0,0, retExp[i], retUpc[i] + 11'h001, 1, 1);
            stepCheck($sformatf("ret%0d", i), cv);
        end
        stepCheck("after_underflow", mkv(1,0,NOP,0,0,0,0,0,11'h001,11'h001,1,1));

        // Reset asserted mid-cycle while a JMP is presented.
        @(negedge clk);
        applyStimulus(mkv(1,0,enc(3,0,11'h200),0,0,0,0,0,0,0,0,0));
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset", mkv(1,0,0,0,0,0,0,0,11'h000,11'h001,0,0));

        // Release with the stale word still on inst_in: it must be ignored.
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(mkv(1,0,enc(3,0,11'h200),0,0,0,0,0,0,0,0,0));
        #1;
        checkOutput("post_reset_first", mkv(1,0,0,0,0,0,0,0,11'h000,11'h001,0,0));
        stepCheck("post_reset_seq", mkv(1,0,NOP,0,0,0,0,0,11'h001,11'h001,1,0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
